// File: rtl/quad_enc_pkg.sv
// Shared constants for the quadrature encoder reader: register map, control/status
// bit positions and the per-cycle step encoding produced by the decoder.
package quad_enc_pkg;

  localparam logic [3:0] ADDR_POSITION  = 4'd0;
  localparam logic [3:0] ADDR_VELOCITY  = 4'd1;
  localparam logic [3:0] ADDR_INDEX_POS = 4'd2;
  localparam logic [3:0] ADDR_STATUS    = 4'd3;
  localparam logic [3:0] ADDR_ERR_COUNT = 4'd4;
  localparam logic [3:0] ADDR_CONTROL   = 4'd5;
  localparam logic [3:0] ADDR_CLEAR     = 4'd6;

  localparam int CTRL_ENABLE   = 0;
  localparam int CTRL_ZERO_IDX = 1;
  localparam int CTRL_INVERT   = 2;

  localparam int STAT_IDX      = 0;
  localparam int STAT_ERR      = 1;
  localparam int STAT_DIR      = 2;
  localparam int STAT_FILT_LSB = 4;

  localparam int CLR_IDX = 0;
  localparam int CLR_ERR = 1;

  localparam logic [2:0]  CONTROL_RESET = 3'b001;
  localparam logic [31:0] READ_DEFAULT  = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    STEP_NONE = 2'b00,
    STEP_FWD  = 2'b01,
    STEP_REV  = 2'b10,
    STEP_ERR  = 2'b11
  } step_t;

  // Position of an {A,B} level within the forward cycle 00 -> 10 -> 11 -> 01.
  function automatic logic [1:0] gray_phase(input logic [1:0] ab);
    case (ab)
      2'b00:   gray_phase = 2'd0;
      2'b10:   gray_phase = 2'd1;
      2'b11:   gray_phase = 2'd2;
      default: gray_phase = 2'd3;
    endcase
  endfunction

  function automatic step_t decode_step(input logic [1:0] prev_ab, input logic [1:0] cur_ab);
    logic [1:0] diff;
    diff = gray_phase(cur_ab) - gray_phase(prev_ab);
    case (diff)
      2'd0:    decode_step = STEP_NONE;
      2'd1:    decode_step = STEP_FWD;
      2'd3:    decode_step = STEP_REV;
      default: decode_step = STEP_ERR;
    endcase
  endfunction

endpackage

// File: rtl/quad_input_filter.sv
// One encoder channel: 2-FF synchronizer followed by a glitch filter that only
// accepts a new level after it has been stable for FILTER_LEN consecutive cycles.
module quad_input_filter #(
  parameter int FILTER_LEN = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic async_i,
  output logic filt_o
);

  localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FILTER_LEN - 1);

  logic [1:0]       sync_q;
  logic             filt_q, filt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      filt_q <= 1'b0;
      cnt_q  <= CNT_LOAD;
    end else begin
      sync_q <= {sync_q[0], async_i};
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

  // Down-counter reloads whenever the input agrees with the output.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = CNT_LOAD;
    if (sync_q[1] != filt_q) begin
      if (cnt_q == '0) filt_d = sync_q[1];
      else             cnt_d  = cnt_q - 1'b1;
    end
  end

  assign filt_o = filt_q;

endmodule

// File: rtl/quad_encoder_reader.sv
// Quadrature encoder reader with Avalon-MM register access: filtered A/B/I decode,
// position, windowed velocity, index capture and transition-error accounting.
module quad_encoder_reader
  import quad_enc_pkg::*;
#(
  parameter int FILTER_LEN = 4,
  parameter int VEL_WINDOW = 50000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  avs_s0_address,
  input  logic        avs_s0_write,
  input  logic [31:0] avs_s0_writedata,
  input  logic        avs_s0_read,
  output logic [31:0] avs_s0_readdata,
  output logic        avs_s0_waitrequest,
  input  logic        enc_a,
  input  logic        enc_b,
  input  logic        enc_i
);

  localparam int WIN_W = (VEL_WINDOW > 1) ? $clog2(VEL_WINDOW) : 1;
  localparam logic [WIN_W-1:0] WIN_LOAD = WIN_W'(VEL_WINDOW - 1);
  // Decoding stays masked after reset until the filters have caught up with the pins.
  localparam int SETTLE_LEN = FILTER_LEN + 4;
  localparam int SETTLE_W   = $clog2(SETTLE_LEN + 1);
  localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_LEN);

  logic a_f, b_f, i_f;

  quad_input_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_a (
    .clk(clk), .reset_n(reset_n), .async_i(enc_a), .filt_o(a_f));
  quad_input_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_b (
    .clk(clk), .reset_n(reset_n), .async_i(enc_b), .filt_o(b_f));
  quad_input_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_i (
    .clk(clk), .reset_n(reset_n), .async_i(enc_i), .filt_o(i_f));

  logic [1:0]          ab_prev_q;
  logic                i_prev_q;
  logic [SETTLE_W-1:0] settle_q, settle_d;
  logic [31:0]         position_q, position_d;
  logic [31:0]         velocity_q, velocity_d;
  logic [31:0]         index_pos_q, index_pos_d;
  logic [31:0]         win_delta_q, win_delta_d;
  logic [WIN_W-1:0]    win_cnt_q, win_cnt_d;
  logic [15:0]         err_cnt_q, err_cnt_d;
  logic                idx_q, idx_d, err_q, err_d, dir_q, dir_d;
  logic [2:0]          ctrl_q, ctrl_d;
  logic [31:0]         readdata_q, readdata_d;

  step_t       raw_step;
  logic        active, decode_en, move, neg, err_evt, idx_rise;
  logic        wr_pos, wr_ctrl, clr_idx, clr_err;
  logic [31:0] step_val, status_w;

  always_comb begin
    raw_step  = decode_step(ab_prev_q, {a_f, b_f});
    active    = (settle_q == '0);
    decode_en = active && ctrl_q[CTRL_ENABLE];
    move      = decode_en && (raw_step == STEP_FWD || raw_step == STEP_REV);
    neg       = (raw_step == STEP_REV) ^ ctrl_q[CTRL_INVERT];
    err_evt   = decode_en && (raw_step == STEP_ERR);
    idx_rise  = active && i_f && !i_prev_q;
    step_val  = '0;
    if (move) step_val = neg ? 32'hFFFF_FFFF : 32'd1;

    wr_pos  = avs_s0_write && (avs_s0_address == ADDR_POSITION);
    wr_ctrl = avs_s0_write && (avs_s0_address == ADDR_CONTROL);
    clr_idx = avs_s0_write && (avs_s0_address == ADDR_CLEAR) && avs_s0_writedata[CLR_IDX];
    clr_err = avs_s0_write && (avs_s0_address == ADDR_CLEAR) && avs_s0_writedata[CLR_ERR];

    status_w                         = '0;
    status_w[STAT_IDX]               = idx_q;
    status_w[STAT_ERR]               = err_q;
    status_w[STAT_DIR]               = dir_q;
    status_w[STAT_FILT_LSB +: 3]     = {i_f, b_f, a_f};
  end

  always_comb begin
    settle_d    = (settle_q == '0) ? settle_q : settle_q - 1'b1;
    position_d  = position_q + step_val;
    velocity_d  = velocity_q;
    index_pos_d = index_pos_q;
    win_delta_d = win_delta_q + step_val;
    win_cnt_d   = win_cnt_q - 1'b1;
    err_cnt_d   = err_cnt_q;
    idx_d       = idx_rise | (idx_q & ~clr_idx);
    err_d       = err_evt | (err_q & ~clr_err);
    dir_d       = move ? neg : dir_q;
    ctrl_d      = wr_ctrl ? avs_s0_writedata[2:0] : ctrl_q;
    readdata_d  = readdata_q;

    if (wr_pos)
      position_d = avs_s0_writedata;
    else if (idx_rise && ctrl_q[CTRL_ZERO_IDX])
      position_d = step_val;

    if (idx_rise) index_pos_d = position_q;

    if (win_cnt_q == '0) begin
      velocity_d  = win_delta_q + step_val;
      win_delta_d = '0;
      win_cnt_d   = WIN_LOAD;
    end

    // A clear in the same cycle as a new error leaves the new error counted.
    if (clr_err)
      err_cnt_d = err_evt ? 16'd1 : 16'd0;
    else if (err_evt && err_cnt_q != 16'hFFFF)
      err_cnt_d = err_cnt_q + 16'd1;

    if (avs_s0_read) begin
      case (avs_s0_address)
        ADDR_POSITION:  readdata_d = position_q;
        ADDR_VELOCITY:  readdata_d = velocity_q;
        ADDR_INDEX_POS: readdata_d = index_pos_q;
        ADDR_STATUS:    readdata_d = status_w;
        ADDR_ERR_COUNT: readdata_d = {16'd0, err_cnt_q};
        ADDR_CONTROL:   readdata_d = {29'd0, ctrl_q};
        ADDR_CLEAR:     readdata_d = '0;
        default:        readdata_d = READ_DEFAULT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ab_prev_q   <= '0;
      i_prev_q    <= 1'b0;
      settle_q    <= SETTLE_LOAD;
      position_q  <= '0;
      velocity_q  <= '0;
      index_pos_q <= '0;
      win_delta_q <= '0;
      win_cnt_q   <= WIN_LOAD;
      err_cnt_q   <= '0;
      idx_q       <= 1'b0;
      err_q       <= 1'b0;
      dir_q       <= 1'b0;
      ctrl_q      <= CONTROL_RESET;
      readdata_q  <= '0;
    end else begin
      ab_prev_q   <= {a_f, b_f};
      i_prev_q    <= i_f;
      settle_q    <= settle_d;
      position_q  <= position_d;
      velocity_q  <= velocity_d;
      index_pos_q <= index_pos_d;
      win_delta_q <= win_delta_d;
      win_cnt_q   <= win_cnt_d;
      err_cnt_q   <= err_cnt_d;
      idx_q       <= idx_d;
      err_q       <= err_d;
      dir_q       <= dir_d;
      ctrl_q      <= ctrl_d;
      readdata_q  <= readdata_d;
    end
  end

  assign avs_s0_readdata    = readdata_q;
  assign avs_s0_waitrequest = 1'b0;

endmodule

// File: tb/tb_quad_encoder_reader.sv
// Self-checking bench for quad_encoder_reader: register vectors, directed corner
// sequences and random motion against a move-level reference model.
`timescale 1ns/1ps
module tb_quad_encoder_reader;

  localparam int FL = 4;
  localparam int VW = 2000;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  addr = '0;
  logic        wr = 1'b0, rd = 1'b0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        waitreq;
  logic        enc_a = 1'b0, enc_b = 1'b0, enc_i = 1'b0;

  int n_chk = 0;
  int n_pass = 0;

  // Reference model: encoder phase, position and error bookkeeping by move intent.
  int         m_g = 0;
  int         m_pos = 0;
  int         m_errcnt = 0;
  bit         m_err = 0, m_dir = 0;
  logic [2:0] m_ctrl = 3'b001;

  quad_encoder_reader #(.FILTER_LEN(FL), .VEL_WINDOW(VW)) dut (
    .clk(clk), .reset_n(reset_n),
    .avs_s0_address(addr), .avs_s0_write(wr), .avs_s0_writedata(wdata),
    .avs_s0_read(rd), .avs_s0_readdata(rdata), .avs_s0_waitrequest(waitreq),
    .enc_a(enc_a), .enc_b(enc_b), .enc_i(enc_i));

  always #10 clk = ~clk;

  typedef struct {
    bit          do_wr;
    logic [3:0]  wa;
    logic [31:0] wd;
    logic [3:0]  ra;
    logic [31:0] exp;
    string       name;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h required 0x%08h", name, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_wr(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    addr = a; wdata = d; wr = 1'b1;
    @(negedge clk);
    wr = 1'b0;
  endtask

  task automatic bus_rd(input logic [3:0] a, output logic [31:0] d);
    @(negedge clk);
    addr = a; rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
    d = rdata;
  endtask

  function automatic logic [1:0] ab_of(input int g);
    case (g)
      0:       return 2'b00;
      1:       return 2'b10;
      2:       return 2'b11;
      default: return 2'b01;
    endcase
  endfunction

  // d = 1 forward edge, 3 reverse edge, 2 illegal double change; one call lasts per cycles.
  task automatic enc_move(input int d, input int per);
    int s;
    @(negedge clk);
    m_g = (m_g + d) % 4;
    {enc_a, enc_b} = ab_of(m_g);
    if (m_ctrl[0]) begin
      if (d == 2) begin
        m_err = 1;
        if (m_errcnt < 65535) m_errcnt++;
      end else begin
        s = (d == 1) ? 1 : -1;
        if (m_ctrl[2]) s = -s;
        m_pos = m_pos + s;
        m_dir = (s < 0);
      end
    end
    tick(per - 1);
  endtask

  task automatic set_ctrl(input logic [2:0] c);
    m_ctrl = c;
    bus_wr(4'd5, {29'd0, c});
  endtask

  initial begin
    logic [31:0] v, held;
    vec_t vecs[10];
    int r;

    vecs[0] = '{1, 4'd0, 32'h1234_5678, 4'd0, 32'h1234_5678, "pos_rw"};
    vecs[1] = '{1, 4'd5, 32'h0000_0005, 4'd5, 32'h0000_0005, "ctrl_rw"};
    vecs[2] = '{1, 4'd5, 32'h0000_0001, 4'd5, 32'h0000_0001, "ctrl_restore"};
    vecs[3] = '{1, 4'd9, 32'h0000_FFFF, 4'd9, 32'hDEAD_BEEF, "unmapped_9"};
    vecs[4] = '{0, 4'd0, 32'h0,         4'd15, 32'hDEAD_BEEF, "unmapped_15"};
    vecs[5] = '{1, 4'd1, 32'h0000_0055, 4'd1, 32'h0000_0000, "vel_ro"};
    vecs[6] = '{1, 4'd2, 32'h0000_0077, 4'd2, 32'h0000_0000, "idxpos_ro"};
    vecs[7] = '{1, 4'd4, 32'h0000_0005, 4'd4, 32'h0000_0000, "errcnt_ro"};
    vecs[8] = '{1, 4'd0, 32'h0000_0000, 4'd0, 32'h0000_0000, "pos_zero"};
    vecs[9] = '{1, 4'd5, 32'hFFFF_FFF9, 4'd5, 32'h0000_0001, "ctrl_width"};

    tick(3);
    check("reset_readdata", rdata, 32'h0);
    check("waitrequest", {31'd0, waitreq}, 32'h0);
    @(negedge clk) reset_n = 1'b1;
    tick(FL + 10);

    bus_rd(4'd0, v); check("rst_pos", v, 32'h0);
    bus_rd(4'd1, v); check("rst_vel", v, 32'h0);
    bus_rd(4'd2, v); check("rst_idxpos", v, 32'h0);
    bus_rd(4'd3, v); check("rst_status", v, 32'h0);
    bus_rd(4'd4, v); check("rst_errcnt", v, 32'h0);
    bus_rd(4'd5, v); check("rst_ctrl", v, 32'h1);

    foreach (vecs[k]) begin
      if (vecs[k].do_wr) bus_wr(vecs[k].wa, vecs[k].wd);
      bus_rd(vecs[k].ra, v);
      check(vecs[k].name, v, vecs[k].exp);
    end
    m_pos = 0;

    // 400 forward quadrature cycles
    repeat (1600) enc_move(1, 8);
    tick(10);
    bus_rd(4'd0, v); check("fwd_1600_pos", v, 32'd1600);
    bus_rd(4'd3, v); check("fwd_dir", {31'd0, v[2]}, 32'h0);

    // readdata holds until the next read
    held = v;
    enc_move(1, 12);
    check("rd_hold", rdata, held);

    // 2-cycle glitch on A
    @(negedge clk) enc_a = ~enc_a;
    tick(2);
    enc_a = ~enc_a;
    tick(12);
    bus_rd(4'd0, v); check("glitch_pos", v, 32'(m_pos));
    bus_rd(4'd4, v); check("glitch_errcnt", v, 32'h0);

    // illegal double transition
    enc_move(2, 12);
    bus_rd(4'd0, v); check("jump_pos", v, 32'(m_pos));
    bus_rd(4'd3, v); check("jump_err", {31'd0, v[1]}, 32'h1);
    bus_rd(4'd4, v); check("jump_errcnt", v, 32'd1);
    bus_wr(4'd6, 32'h2);
    m_err = 0; m_errcnt = 0;
    bus_rd(4'd3, v); check("clr_err", {31'd0, v[1]}, 32'h0);
    bus_rd(4'd4, v); check("clr_errcnt", v, 32'h0);

    // velocity: 1 edge per 20 cycles over a 2000-cycle window
    fork
      repeat (250) enc_move(1, 20);
      begin tick(4500); bus_rd(4'd1, v); check("vel_fwd", v, 32'd100); end
    join
    fork
      repeat (250) enc_move(3, 20);
      begin tick(4500); bus_rd(4'd1, v); check("vel_rev", v, 32'hFFFF_FF9C); end
    join
    tick(10);
    bus_rd(4'd0, v); check("vel_pos", v, 32'(m_pos));

    // two's-complement wrap
    bus_wr(4'd0, 32'h7FFF_FFFF);
    m_pos = 32'h7FFF_FFFF;
    enc_move(1, 12);
    bus_rd(4'd0, v); check("wrap_pos", v, 32'h8000_0000);

    // index capture with zeroing
    bus_wr(4'd0, 32'd500);
    set_ctrl(3'b011);
    @(negedge clk) enc_i = 1'b1;
    tick(12);
    bus_rd(4'd2, v); check("idx_latch", v, 32'd500);
    bus_rd(4'd0, v); check("idx_zero_pos", v, 32'h0);
    bus_rd(4'd3, v); check("idx_sticky", {31'd0, v[0]}, 32'h1);
    enc_i = 1'b0;
    tick(12);
    bus_wr(4'd6, 32'h1);
    bus_rd(4'd3, v); check("idx_clear", {31'd0, v[0]}, 32'h0);
    set_ctrl(3'b001);
    m_pos = 0;

    // enable=0 ignores moves and errors, no spurious step on re-enable
    set_ctrl(3'b000);
    repeat (5) enc_move(1, 10);
    enc_move(2, 10);
    set_ctrl(3'b001);
    tick(10);
    bus_rd(4'd0, v); check("dis_pos", v, 32'(m_pos));
    bus_rd(4'd4, v); check("dis_errcnt", v, 32'(m_errcnt));
    enc_move(1, 12);
    bus_rd(4'd0, v); check("reen_pos", v, 32'(m_pos));

    // random motion, invert and enable against the model
    for (int n = 0; n < 80; n++) begin
      r = $urandom_range(0, 9);
      if (r <= 3)      enc_move(1, 10);
      else if (r <= 5) enc_move(3, 10);
      else if (r == 6) enc_move(2, 10);
      else if (r == 7) tick(10);
      else if (r == 8) set_ctrl(m_ctrl ^ 3'b100);
      else             set_ctrl(m_ctrl ^ 3'b001);
      tick(2);
      bus_rd(4'd0, v); check("rand_pos", v, 32'(m_pos));
    end
    bus_rd(4'd4, v); check("rand_errcnt", v, 32'(m_errcnt));
    bus_rd(4'd3, v); check("rand_status", {29'd0, v[2:0]}, {29'd0, m_dir, m_err, 1'b0});
    set_ctrl(3'b001);

    // reset in mid-motion with A high, B low
    while (m_g != 1) enc_move(1, 10);
    enc_move(1, 3);
    enc_move(3, 3);
    @(negedge clk) reset_n = 1'b0;
    #1 check("mid_rst_readdata", rdata, 32'h0);
    tick(3);
    @(negedge clk) reset_n = 1'b1;
    m_pos = 0; m_errcnt = 0; m_err = 0; m_dir = 0; m_ctrl = 3'b001;
    tick(FL + 12);
    bus_rd(4'd0, v); check("post_rst_pos", v, 32'h0);
    bus_rd(4'd4, v); check("post_rst_errcnt", v, 32'h0);
    bus_rd(4'd1, v); check("post_rst_vel", v, 32'h0);
    bus_rd(4'd2, v); check("post_rst_idxpos", v, 32'h0);
    bus_rd(4'd5, v); check("post_rst_ctrl", v, 32'h1);
    bus_rd(4'd3, v); check("post_rst_status", v, 32'h10);
    enc_move(1, 12);
    bus_rd(4'd0, v); check("post_rst_step", v, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/quad_encoder_reader.md
QUAD_ENCODER_READER -- requirements
Module: quad_encoder_reader

Interface
REQ-001 Parameter FILTER_LEN, default 4: consecutive stable cycles needed to accept a new A/B/I level.
REQ-002 Parameter VEL_WINDOW, default 50000: velocity window in clk cycles (1 ms at 50 MHz).
REQ-003 clk  input  1  50 MHz clock.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 avs_s0_address  input  4  Avalon-MM word address.
REQ-006 avs_s0_write  input  1  write strobe.
REQ-007 avs_s0_writedata  input  32  write data.
REQ-008 avs_s0_read  input  1  read strobe.
REQ-009 avs_s0_readdata  output  32  read data, registered.
REQ-010 avs_s0_waitrequest  output  1  tied 0.
REQ-011 enc_a, enc_b, enc_i  input  1 each  asynchronous encoder channels A, B and index.

Function
REQ-012 Each of A, B, I SHALL pass a 2-FF synchronizer, then a filter whose output changes only after the synchronized input differs from it for FILTER_LEN consecutive cycles.
REQ-013 The decoder SHALL compare the filtered {A,B} with the previous cycle: sequence 00->10->11->01->00 = +1; reverse = -1; no change = 0; control.invert negates the sign.
REQ-014 A transition in which both bits change SHALL leave position unchanged, set sticky status.err and increment error_count, saturating at 0xFFFF.
REQ-015 position SHALL be 32-bit signed and wrap two's-complement (0x7FFFFFFF +1 -> 0x80000000).
REQ-016 A window counter SHALL count 0..VEL_WINDOW-1. At the terminal cycle, velocity <= window_delta plus the step of that cycle, and window_delta clears. Otherwise window_delta accumulates steps (signed 32-bit).
REQ-017 On a filtered I rising edge, index_pos SHALL latch the position value before that cycle's step, and sticky status.idx SHALL be set.
REQ-018 If control.zero_idx=1 on an I rising edge, position SHALL become that cycle's step (0/+1/-1).
REQ-019 A host write to address 0 SHALL override decoding and zeroing in the same cycle; window_delta is unaffected.
REQ-020 With control.enable=0, steps and errors SHALL be ignored, while filters and the previous-state register keep tracking, so re-enable produces no spurious step.
REQ-021 Register map (R=read, W=write):
  0 position R/W
  1 velocity R
  2 index_pos R
  3 status R: [0]idx, [1]err, [2]last direction (1=negative), [6:4] filtered {I,B,A}
  4 error_count R
  5 control R/W: [0]enable, [1]zero_idx, [2]invert
  6 clear W: [0] clears idx, [1] clears err and error_count
  All other read addresses return 0xDEADBEEF; writes to them are ignored.
REQ-022 Read data SHALL appear on avs_s0_readdata the cycle after avs_s0_read and hold until the next read.
REQ-023 If a clear of a sticky bit coincides with a new set event, set SHALL win.

Reset
REQ-024 On reset_n low: position, velocity, index_pos, error_count, window state, sticky bits and readdata = 0; control = 0x1; filter outputs and previous-state register = 0.
REQ-025 Reset asserted mid-window SHALL discard the partial window; the first velocity after release covers a full VEL_WINDOW.

Structure
REQ-026 Shared package quad_enc_pkg SHALL hold the register address constants, control/status bit indices and the 2-bit step-encoding typedef.
REQ-027 Sub-module quad_input_filter (synchronizer + FILTER_LEN filter) SHALL be instantiated three times.

Verification
REQ-028 Drive 400 forward quadrature cycles at 10 us/edge, enable=1 -> position = 1600, status[2] = 0.
REQ-029 Apply a 2-cycle glitch on A with FILTER_LEN=4 -> position unchanged, no error.
REQ-030 Jump AB 00->11 -> position unchanged, status.err = 1, error_count = 1; write 6 with 0x2 -> both cleared.
REQ-031 Constant 1 edge/10 us with VEL_WINDOW=50000 -> velocity = +100 after the second window; reversed direction -> -100.
REQ-032 Write position 0x7FFFFFFF, then 1 forward edge -> 0x80000000; with zero_idx=1, index pulse at position 500 -> index_pos = 500, position = 0, idx = 1.
REQ-033 Assert reset_n mid-motion -> all registers 0 and control = 0x1 immediately; no step is counted on release.
